ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with the architectural HI/LO registers. It sits in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched ALU operands and a decoded mul/div opcode, and runs MULT/MULTU/DIV/DIVU in a radix-2 shift loop.
- Executes MTHI/MTLO and supplies HI/LO for MFHI/MFLO.
- Requests a pipeline stall while a HI/LO consumer, or a new mul/div, meets a busy unit.

---
 rtl/ex_muldiv_unit_pkg.sv | 23 ++
 rtl/ex_muldiv_unit_if.sv | 24 ++
 rtl/ex_muldiv_unit_iter_core.sv | 64 ++++++
 rtl/ex_muldiv_unit.sv | 120 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: opcodes, FSM states, counter width.
package ex_muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [2:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_MULTU = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_DIVU  = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hilo_read;
  logic             abort;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hilo_read, abort,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hilo_read, abort,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply and restoring divide on magnitudes, one step per enable.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff;

  // Both datapaths step every cycle; the top picks whichever result applies.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    shifted = {rem_q, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvsr});
    diff    = shifted[WIDTH-1:0] - dvsr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      mcand <= '0;
      dvsr  <= '0;
      rem_q <= '0;
      quo   <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, b_mag};
      mcand <= a_mag;
      dvsr  <= b_mag;
      rem_q <= '0;
      quo   <= a_mag;
    end else if (step) begin
      acc <= {add_sum, acc[WIDTH-1:1]};
      if (ge) begin
        rem_q <= diff;
        quo   <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo   <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign prod = acc;
  assign quot = quo;
  assign rem  = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide with architectural HI/LO and stall generation.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  ex_muldiv_unit_if.slave     md
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               is_div, sgn_ab, sgn_a, div_zero;
  logic [WIDTH-1:0]   a_raw;

  logic               op_muldiv, op_signed, op_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot, rem, quot_s, rem_s;
  logic               load;

  always_comb begin
    op_muldiv = (md.op == MD_OP_MULT) || (md.op == MD_OP_MULTU) ||
                (md.op == MD_OP_DIV)  || (md.op == MD_OP_DIVU);
    op_signed = (md.op == MD_OP_MULT) || (md.op == MD_OP_DIV);
    op_div    = (md.op == MD_OP_DIV)  || (md.op == MD_OP_DIVU);
    a_mag     = (op_signed && md.src_a[WIDTH-1]) ? (~md.src_a + 1'b1) : md.src_a;
    b_mag     = (op_signed && md.src_b[WIDTH-1]) ? (~md.src_b + 1'b1) : md.src_b;
    load      = (state == MD_IDLE) && md.start && !md.abort && op_muldiv;
    prod_s    = sgn_ab ? (~prod + 1'b1) : prod;
    quot_s    = sgn_ab ? (~quot + 1'b1) : quot;
    rem_s     = sgn_a  ? (~rem  + 1'b1) : rem;
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (state == MD_RUN),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .prod  (prod),
    .quot  (quot),
    .rem   (rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div   <= 1'b0;
      sgn_ab   <= 1'b0;
      sgn_a    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (md.start && !md.abort) begin
            if (op_muldiv) begin
              state    <= MD_RUN;
              cnt      <= '0;
              is_div   <= op_div;
              sgn_ab   <= op_signed && (md.src_a[WIDTH-1] ^ md.src_b[WIDTH-1]);
              sgn_a    <= op_signed && md.src_a[WIDTH-1];
              div_zero <= (md.src_b == '0);
              a_raw    <= md.src_a;
            end else if (md.op == MD_OP_MTHI) begin
              hi_q <= md.src_a;
            end else if (md.op == MD_OP_MTLO) begin
              lo_q <= md.src_a;
            end
          end
        end
        MD_RUN: begin
          if (md.abort) begin
            state <= MD_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) state <= MD_FIX;
          end
        end
        MD_FIX: begin
          state <= MD_IDLE;
          if (!md.abort) begin
            done_q <= 1'b1;
            if (!is_div) begin
              hi_q <= prod_s[2*WIDTH-1:WIDTH];
              lo_q <= prod_s[WIDTH-1:0];
            end else if (div_zero) begin
              // Divide by zero leaves a recognisable pattern rather than the raw loop output.
              hi_q <= a_raw;
              lo_q <= '1;
            end else begin
              hi_q <= rem_s;
              lo_q <= quot_s;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign md.busy      = (state != MD_IDLE);
  assign md.stall_req = md.busy && (md.hilo_read || md.start);
  assign md.done      = done_q;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table for mul/div results plus stall, abort and reset sequences.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(W)) mif ();

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue a mul/div at E0 and wait for done; returns edges-to-done and busy samples.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    mif.start = 1'b1; mif.op = op; mif.src_a = a; mif.src_b = b;
    @(posedge clk); #1;
    bcnt = mif.busy ? 1 : 0;
    lat  = -1;
    @(negedge clk);
    mif.start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mif.busy) bcnt++;
      if (mif.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic mt(input logic [2:0] op, input logic [W-1:0] a);
    @(negedge clk);
    mif.start = 1'b1; mif.op = op; mif.src_a = a;
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  initial begin
    int lat, bcnt, scnt, dcnt;

    vecs[0] = '{3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[4] = '{3'd4, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF};
    vecs[5] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[6] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[7] = '{3'd3, 32'hFFFF_EDCC, 32'd0,         32'hFFFF_EDCC, 32'hFFFF_FFFF};

    reset = 1'b0;
    mif.start = 1'b0; mif.op = 3'd0; mif.src_a = '0; mif.src_b = '0;
    mif.hilo_read = 1'b0; mif.abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'b0, mif.busy},      32'd0);
    check("rst_done",  {31'b0, mif.done},      32'd0);
    check("rst_stall", {31'b0, mif.stall_req}, 32'd0);
    check("rst_hi",    mif.hi,                 32'd0);
    check("rst_lo",    mif.lo,                 32'd0);
    reset = 1'b1;

    // MTHI then MTLO back to back
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd5; mif.src_a = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    check("mthi_hi",   mif.hi, 32'hA5A5_A5A5);
    check("mthi_busy", {31'b0, mif.busy}, 32'd0);
    @(negedge clk);
    mif.op = 3'd6; mif.src_a = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    check("mtlo_lo",   mif.lo, 32'h5A5A_5A5A);
    check("mtlo_hi",   mif.hi, 32'hA5A5_A5A5);
    check("mtlo_busy", {31'b0, mif.busy}, 32'd0);
    @(negedge clk);
    mif.start = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, lat, bcnt);
      check($sformatf("v%0d_latency", v), lat,  W + 1);
      check($sformatf("v%0d_busy", v),    bcnt, W + 1);
      check($sformatf("v%0d_hi", v),      mif.hi, vecs[v].hi);
      check($sformatf("v%0d_lo", v),      mif.lo, vecs[v].lo);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", v), {31'b0, mif.done}, 32'd0);
    end

    // MULTU with a HI/LO reader and a second start arriving while busy
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd2; mif.src_a = 32'hFFFF_FFFF; mif.src_b = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0; mif.hilo_read = 1'b1;
    #1 check("stall_first", {31'b0, mif.stall_req}, 32'd1);
    scnt = 0; lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mif.stall_req) scnt++;
      if (i == 5) begin
        mif.hilo_read = 1'b0; mif.start = 1'b1; mif.op = 3'd6; mif.src_a = 32'h0BAD;
        #1 check("stall_on_start", {31'b0, mif.stall_req}, 32'd1);
        @(negedge clk);
        mif.start = 1'b0; mif.hilo_read = 1'b1;
      end
      if (mif.done) begin
        lat = i;
        break;
      end
    end
    check("stall_latency", lat, W + 1);
    check("stall_cycles",  scnt, W);
    check("stall_release", {31'b0, mif.stall_req}, 32'd0);
    check("multu_hi", mif.hi, 32'hFFFF_FFFE);
    check("multu_lo", mif.lo, 32'h0000_0001);
    @(negedge clk);
    mif.hilo_read = 1'b0;

    // Abort at RUN cycle 10
    mt(3'd5, 32'h1111_1111);
    mt(3'd6, 32'h1111_1111);
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd1; mif.src_a = 32'd7; mif.src_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    mif.abort = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'b0, mif.busy}, 32'd0);
    @(negedge clk);
    mif.abort = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mif.done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_hi", mif.hi, 32'h1111_1111);
    check("abort_lo", mif.lo, 32'h1111_1111);

    // abort alongside an IDLE MTHI suppresses it
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd5; mif.src_a = 32'hDEAD_BEEF; mif.abort = 1'b1;
    @(posedge clk); #1;
    check("abort_idle_hi",   mif.hi, 32'h1111_1111);
    check("abort_idle_busy", {31'b0, mif.busy}, 32'd0);
    @(negedge clk);
    mif.start = 1'b0; mif.abort = 1'b0;

    // Reset mid-RUN
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd1; mif.src_a = 32'd3; mif.src_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'b0, mif.busy}, 32'd0);
    check("midrst_hi",   mif.hi, 32'd0);
    check("midrst_lo",   mif.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("midrst_idle", {31'b0, mif.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
